// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one-at-a-time access to a single memory port.
// Defining MEM_ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYCLES cycles.
module mem_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [512*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [511:0]           rsp_data,
  output logic                   timeout_err,
  input  logic                   buffer_addr_valid,
  input  logic                   data_valid,
  input  logic                   write_done,
  input  logic [511:0]           mem_rdata,
  output logic                   mem_rd_valid,
  output logic                   mem_wr_valid,
  output logic [31:0]            mem_address,
  output logic [511:0]           mem_wdata
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_last_id;
  logic            r_write;
  logic [ID_W-1:0] w_sel_id;
  logic            w_sel_found;
  logic            w_accept;
  logic            w_complete;
  logic            w_timeout;
  logic [31:0]     w_addr  [NUM_REQ];
  logic [511:0]    w_wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[32*g +: 32];
    assign w_wdata[g] = req_wdata[512*g +: 512];
  end

  // Search starts just after the last completed requester so nobody is starved.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_sel_id    = '0;
    w_sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin : rr_search
      int idx;
      idx = int'(r_last_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_sel_found && req_valid[ID_W'(idx)]) begin
        w_sel_found = 1'b1;
        w_sel_id    = ID_W'(idx);
      end
    end
  end

  // Selection waits out the rsp_done cycle, which keeps grants at least four cycles apart.
  assign w_accept   = (r_state == S_IDLE) && buffer_addr_valid && w_sel_found && (rsp_done == '0);
  assign w_complete = (r_state == S_WAIT) && (r_write ? write_done : data_valid);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_timeout)              r_timeout_err <= 1'b1;
    end
  end

  assign w_timeout   = (r_state == S_WAIT) && !w_complete &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    req_grant    = '0;
    mem_rd_valid = 1'b0;
    mem_wr_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: begin
        req_grant[r_id] = 1'b1;
        mem_rd_valid    = !r_write;
        mem_wr_valid    = r_write;
        w_next          = S_WAIT;
      end
      S_WAIT:  if (w_complete || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset too, since reset must leave every output at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id        <= '0;
      r_last_id   <= ID_W'(NUM_REQ - 1);
      r_write     <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rsp_data    <= '0;
      rsp_done    <= '0;
    end else begin
      rsp_done <= '0;
      if (w_accept) begin
        r_id        <= w_sel_id;
        r_write     <= req_write[w_sel_id];
        mem_address <= w_addr[w_sel_id];
        mem_wdata   <= w_wdata[w_sel_id];
      end
      if (w_complete || w_timeout) begin
        rsp_done[r_id] <= 1'b1;
        r_last_id      <= r_id;
        if (w_complete && !r_write) rsp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/completions, a monitor compares them.
// Build with MEM_ARB_TIMEOUT_EN defined to exercise the timeout abort.
module tb_mem_arbiter;

  localparam int NR  = 3;
  localparam int TMO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_BUILD = 1'b1;
`else
  localparam bit TMO_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_write = '0;
  logic [32*NR-1:0]  req_addr  = '0;
  logic [512*NR-1:0] req_wdata = '0;
  logic [NR-1:0]     req_grant;
  logic [NR-1:0]     rsp_done;
  logic [511:0]      rsp_data;
  logic              timeout_err;
  logic              buffer_addr_valid = 1'b0;
  logic              data_valid = 1'b0;
  logic              write_done = 1'b0;
  logic [511:0]      mem_rdata = '0;
  logic              mem_rd_valid;
  logic              mem_wr_valid;
  logic [31:0]       mem_address;
  logic [511:0]      mem_wdata;

  mem_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_done(rsp_done), .rsp_data(rsp_data), .timeout_err(timeout_err),
    .buffer_addr_valid(buffer_addr_valid), .data_valid(data_valid), .write_done(write_done),
    .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid), .mem_wr_valid(mem_wr_valid),
    .mem_address(mem_address), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    bit           wr;
    logic [31:0]  addr;
    logic [511:0] wdata;
    int           cyc;
  } grant_t;

  typedef struct {
    int           id;
    logic [511:0] data;
    bit           tmo;
    int           cyc;
  } done_t;

  grant_t gq[$];
  done_t  dq[$];
  int     total = 0;
  int     bad = 0;
  int     n_grants = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every grant and completion the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if ((mem_rd_valid || mem_wr_valid) && req_grant == '0)
      check("mem_req_without_grant", {mem_rd_valid, mem_wr_valid}, 2'b00);
    if (req_grant != '0) begin
      n_grants++;
      if (gq.size() == 0) begin
        check("grant_unexpected", req_grant, '0);
      end else begin
        grant_t g;
        g = gq.pop_front();
        check("grant_id", req_grant, NR'(1) << g.id);
        check("grant_cycle", cyc, g.cyc);
        check("mem_rd_valid", mem_rd_valid, !g.wr);
        check("mem_wr_valid", mem_wr_valid, g.wr);
        check("mem_address", mem_address, g.addr);
        if (g.wr) check("mem_wdata", mem_wdata, g.wdata);
      end
    end
    if (rsp_done != '0) begin
      if (dq.size() == 0) begin
        check("done_unexpected", rsp_done, '0);
      end else begin
        done_t d;
        d = dq.pop_front();
        check("done_id", rsp_done, NR'(1) << d.id);
        check("done_cycle", cyc, d.cyc);
        check("rsp_data", rsp_data, d.data);
        check("timeout_err", timeout_err, d.tmo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit wr, input logic [31:0] addr, input logic [511:0] wd);
    req_write[id]            = wr;
    req_addr[32*id +: 32]    = addr;
    req_wdata[512*id +: 512] = wd;
    req_valid[id]            = 1'b1;
  endtask

  task automatic expect_grant(input int id, input bit wr, input logic [31:0] addr,
                              input logic [511:0] wd, input int c);
    grant_t g;
    g.id = id; g.wr = wr; g.addr = addr; g.wdata = wd; g.cyc = c;
    gq.push_back(g);
  endtask

  // Memory model: waits for the request pulse, then completes lat cycles later (lat < 0: never).
  // With lat < 0 and exp_tmo set, a timeout abort is expected TMO WAIT cycles after the grant.
  task automatic respond(input int id, input bit wr, input int lat, input logic [511:0] line,
                         input logic [511:0] exp_rsp, input bit exp_tmo, input bit drop,
                         input bit spurious);
    bit    seen;
    int    g;
    done_t d;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = mem_rd_valid || mem_wr_valid;
    end
    if (!seen) begin
      check("mem_req_wait", seen, 1'b1);
      return;
    end
    g = cyc;
    if (drop) req_valid[id] = 1'b0;
    d.id = id; d.data = exp_rsp; d.tmo = exp_tmo;
    if (lat < 0) begin
      if (exp_tmo) begin
        d.cyc = g + TMO + 1;
        dq.push_back(d);
      end
      return;
    end
    d.cyc = g + lat + 1 + (spurious ? 2 : 0);
    dq.push_back(d);
    repeat (lat) @(posedge clk);
    #1;
    if (spurious) begin
      data_valid = 1'b1;
      mem_rdata  = '1;
      tick();
      data_valid = 1'b0;
      tick();
    end
    if (wr) write_done = 1'b1;
    else begin
      data_valid = 1'b1;
      mem_rdata  = line;
    end
    tick();
    write_done = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] last_rd;
    logic [511:0] line;
    int           ng;
    int           n0;

    repeat (3) tick();
    rst = 1'b0;
    buffer_addr_valid = 1'b1;
    tick();
    check("reset_grant", req_grant, '0);
    check("reset_done", rsp_done, '0);
    check("reset_mem_req", {mem_rd_valid, mem_wr_valid}, 2'b00);
    check("reset_addr", mem_address, '0);
    check("reset_wdata", mem_wdata, '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_timeout_err", timeout_err, 1'b0);

    // Single read from requester 0, memory answers 5 cycles after the request.
    line = {64{8'hA5}};
    set_req(0, 1'b0, 32'h100, '0);
    expect_grant(0, 1'b0, 32'h100, '0, cyc + 1);
    respond(0, 1'b0, 5, line, line, 1'b0, 1'b1, 1'b0);
    last_rd = line;
    tick();

    // Write from requester 1 with a stray data_valid during WAIT.
    line = {16{32'h5A5A_0F0F}};
    set_req(1, 1'b1, 32'h200, line);
    expect_grant(1, 1'b1, 32'h200, line, cyc + 1);
    respond(1, 1'b1, 2, '0, last_rd, 1'b0, 1'b1, 1'b1);
    tick();

    // Memory port unavailable: requester 1 waits 20 cycles, granted the cycle after the port rises.
    buffer_addr_valid = 1'b0;
    set_req(1, 1'b0, 32'h240, '0);
    ng = n_grants;
    repeat (20) tick();
    check("no_grant_while_unconfigured", n_grants, ng);
    buffer_addr_valid = 1'b1;
    expect_grant(1, 1'b0, 32'h240, '0, cyc + 1);
    line = {16{32'h1234_5678}};
    respond(1, 1'b0, 1, line, line, 1'b0, 1'b1, 1'b0);
    last_rd = line;
    tick();

    // Reset while requester 2's write is in WAIT; its late write_done must be ignored.
    line = {16{32'hDEAD_BEEF}};
    set_req(2, 1'b1, 32'h300, line);
    expect_grant(2, 1'b1, 32'h300, line, cyc + 1);
    respond(2, 1'b1, -1, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_addr", mem_address, '0);
    check("midreset_rsp_data", rsp_data, '0);
    last_rd = '0;
    write_done = 1'b1;
    tick();
    write_done = 1'b0;
    repeat (3) tick();

    // All three requesters valid continuously with one-cycle memory: order 0,1,2,0,1,2, four-cycle spacing.
    set_req(0, 1'b0, 32'h1000, '0);
    set_req(1, 1'b0, 32'h2000, '0);
    set_req(2, 1'b0, 32'h3000, '0);
    n0 = cyc + 1;
    for (int k = 0; k < 6; k++)
      expect_grant(k % 3, 1'b0, 32'h1000 * ((k % 3) + 1), '0, n0 + 4 * k);
    for (int k = 0; k < 6; k++) begin
      line = {16{32'hC000_0000 + k}};
      respond(k % 3, 1'b0, 1, line, line, 1'b0, 1'b0, 1'b0);
      last_rd = line;
    end
    req_valid = '0;
    tick();
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // No completion: abort after TMO WAIT cycles, rsp_data untouched, flag set.
    set_req(0, 1'b0, 32'h400, '0);
    expect_grant(0, 1'b0, 32'h400, '0, cyc + 1);
    respond(0, 1'b0, -1, '0, last_rd, 1'b1, 1'b1, 1'b0);
    repeat (TMO + 3) tick();
`else
    // Without the timeout feature WAIT simply persists until the late completion.
    line = {16{32'h0BAD_F00D}};
    set_req(0, 1'b0, 32'h400, '0);
    expect_grant(0, 1'b0, 32'h400, '0, cyc + 1);
    respond(0, 1'b0, 30, line, line, 1'b0, 1'b1, 1'b0);
    last_rd = line;
    tick();
`endif

    // A later normal write: the timeout flag, if set, stays set.
    line = {16{32'h7777_1111}};
    set_req(1, 1'b1, 32'h500, line);
    expect_grant(1, 1'b1, 32'h500, line, cyc + 1);
    respond(1, 1'b1, 2, '0, last_rd, TMO_BUILD, 1'b1, 1'b0);
    repeat (3) tick();
    check("timeout_err_final", timeout_err, TMO_BUILD);

    check("grants_outstanding", gq.size(), 0);
    check("dones_outstanding", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 3, number of requesters (0 = control unit, 1 = RDN weight loader, 2 = DNN weight loader).
REQ-002 Parameter: TIMEOUT_CYCLES, 1024, WAIT-state cycles before abort (timeout build only).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester request, held until granted.
REQ-006 req_write  input  NUM_REQ  per-requester type, 1 = write, 0 = read.
REQ-007 req_addr  input  32*NUM_REQ  packed request addresses, slice i = requester i.
REQ-008 req_wdata  input  512*NUM_REQ  packed write lines, slice i = requester i.
REQ-009 req_grant  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-010 rsp_done  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-011 rsp_data  output  512  read line for the requester pulsed on rsp_done.
REQ-012 timeout_err  output  1  sticky abort flag.
REQ-013 buffer_addr_valid  input  1  memory port configured and usable.
REQ-014 data_valid / write_done  input  1 each  memory read / write completion pulses.
REQ-015 mem_rd_valid / mem_wr_valid  output  1 each  memory read / write request pulses.
REQ-016 mem_address  output  32, mem_wdata  output  512: latched request, stable IDLE-exit to completion.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; one transaction outstanding at a time.
REQ-018 IDLE: when buffer_addr_valid=1 and any req_valid=1, select winner round-robin, searching from (last_id+1) mod NUM_REQ upward with wrap-around; latch id, addr, wdata, write; next state ISSUE.
REQ-019 IDLE with buffer_addr_valid=0: no selection, remain IDLE regardless of req_valid.
REQ-020 ISSUE: req_grant[id]=1 and exactly one of mem_rd_valid/mem_wr_valid=1 per latched type, both for this single cycle; next state WAIT.
REQ-021 Latency: request sampled in IDLE at cycle N -> grant and memory request in cycle N+1.
REQ-022 WAIT: ignore req_valid; on data_valid (read) or write_done (write) capture read data into rsp_data (reads only), set last_id=id, pulse rsp_done[id] in the next cycle, return to IDLE.
REQ-023 Completion of the wrong type in WAIT, or any completion in IDLE/ISSUE, is ignored.
REQ-024 rsp_data holds its value until the next read completion; unchanged by writes.
REQ-025 Minimum spacing between consecutive grants: 4 cycles (zero memory latency); a requester never receives back-to-back grants while another requester is valid.

Reset
REQ-026 Asserting rst at any point forces IDLE, last_id=NUM_REQ-1 (requester 0 wins first), all pulses and request outputs 0, mem_address=0, mem_wdata=0, rsp_data=0, timeout_err=0.
REQ-027 Transaction in flight at reset is dropped; its late completion lands in IDLE and is ignored per REQ-023.

Configuration
REQ-028 Macro MEM_ARB_TIMEOUT_EN: when defined, a WAIT cycle counter (reset on WAIT entry) reaching TIMEOUT_CYCLES pulses rsp_done[id], sets timeout_err, leaves rsp_data unchanged, updates last_id, returns to IDLE.
REQ-029 Without MEM_ARB_TIMEOUT_EN: no counter present, timeout_err tied 0, WAIT persists until completion.

Verification
REQ-030 Single read: req0 read addr 0x100, data_valid 5 cycles after mem_rd_valid with 0xA5.. -> grant[0] at N+1, mem_address=0x100, rsp_done[0] with rsp_data=0xA5...
REQ-031 All three valid continuously, immediate completions -> grant order 0,1,2,0,1,2 with REQ-025 spacing.
REQ-032 buffer_addr_valid=0 with req1 valid 20 cycles, then 1 -> no grant until cycle after rise, then grant[1].
REQ-033 rst pulse in WAIT of req2 write, then write_done -> no rsp_done, next grant goes to requester 0.
REQ-034 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no completion -> rsp_done[id] and timeout_err=1 after 8 WAIT cycles; flag stays high through later transactions.
REQ-035 Write pending, spurious data_valid in WAIT -> ignored; write_done -> rsp_done, rsp_data unchanged.
